// File: rtl/ssds_scan_if.sv
// ssds_scan_if: host-side update bus and multiplexed display outputs of the scan controller
interface ssds_scan_if #(parameter int DIGITS = 4);
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dots;
   logic [DIGITS-1:0]   digit_en;
   logic                lzb;
   logic                update;
   logic [6:0]          segments;
   logic                dp;
   logic [DIGITS-1:0]   digit_sel;
   logic                frame_done;
   logic                busy;
   modport master (output value, dots, digit_en, lzb, update,
                   input  segments, dp, digit_sel, frame_done, busy);
   modport slave  (input  value, dots, digit_en, lzb, update,
                   output segments, dp, digit_sel, frame_done, busy);
endinterface

// File: rtl/ssds_scan_controller.sv
// ssds_scan_controller: time-multiplexed seven-segment scan with frame-coherent shadow updates
module ssds_digit_mapper (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb begin
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
   end
endmodule

module ssds_scan_controller #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic       clk,
   input logic       rst_n,
   ssds_scan_if.slave s
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW:0]   ON_END  = (CW+1)'(SCAN_DIV - BLANK_CYCLES);

   logic [IW-1:0]       idx;
   logic [CW-1:0]       cnt;
   logic [4*DIGITS-1:0] sh_val, pd_val, upper;
   logic [DIGITS-1:0]   sh_dots, sh_en, pd_dots, pd_en, sel_q;
   logic                sh_lzb, pd_lzb, pend, dp_q, fd_q;
   logic [6:0]          seg_q, map_seg;
   logic                last, on, supp;

   // upper holds nibble idx and everything above it, so a zero test covers leading zeros
   assign upper = sh_val >> {idx, 2'b00};
   assign last  = cnt == CNT_MAX && idx == IDX_MAX;
   assign on    = {1'b0, cnt} < ON_END;
   assign supp  = !sh_en[idx] || (sh_lzb && idx != '0 && upper == '0);

   ssds_digit_mapper u_map (.nib(upper[3:0]), .seg(map_seg));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx     <= '0;
         cnt     <= '0;
         sh_val  <= '0;
         sh_dots <= '0;
         sh_en   <= '0;
         sh_lzb  <= 1'b0;
         pd_val  <= '0;
         pd_dots <= '0;
         pd_en   <= '0;
         pd_lzb  <= 1'b0;
         pend    <= 1'b0;
         sel_q   <= '0;
         seg_q   <= '0;
         dp_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
         if (cnt == CNT_MAX) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
         // commit reads the old pending copy even if a new update lands this cycle
         if (last && pend) {sh_val, sh_dots, sh_en, sh_lzb} <= {pd_val, pd_dots, pd_en, pd_lzb};
         if (s.update) {pd_val, pd_dots, pd_en, pd_lzb} <= {s.value, s.dots, s.digit_en, s.lzb};
         pend  <= s.update || (pend && !last);
         sel_q <= on ? DIGITS'(1) << idx : '0;
         seg_q <= on && !supp ? map_seg : '0;
         dp_q  <= on && sh_dots[idx];
         fd_q  <= last;
      end
   end

   assign s.segments   = seg_q;
   assign s.dp         = dp_q;
   assign s.digit_sel  = sel_q;
   assign s.frame_done = fd_q;
   assign s.busy       = pend;
endmodule

// File: doc/ssds_scan_controller.md
Name: ssds_scan_controller

Overview:
- Time-multiplexed scan controller for a common-bus seven-segment display bank.
- Holds a coherent shadow copy of the displayed hex value, per-digit decimal points and enable mask.
- Cycles through digits at a fixed slot rate, feeding one nibble at a time through an internal ssds_digit_mapper instance.
- Drives the shared segment bus plus one-hot digit select, with anti-ghosting blanking between slots and optional leading-zero suppression.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 500, cycles at the end of each slot with all outputs dark (0..SCAN_DIV-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- value  in  4*DIGITS  hex nibbles; nibble k = value[4k+3:4k], digit 0 = least significant.
- dots  in  DIGITS  decimal point request per digit.
- digit_en  in  DIGITS  per-digit enable; 0 forces the digit dark.
- lzb  in  1  leading-zero blanking enable.
- update  in  1  single-cycle request to capture value/dots/digit_en/lzb.
- segments  out  7  segment pattern, bit0=a .. bit6=g, active high.
- dp  out  1  decimal point, active high.
- digit_sel  out  DIGITS  one-hot active-high digit select; all-zero when dark.
- frame_done  out  1  one-cycle pulse at each frame boundary.
- busy  out  1  high while a captured update awaits commit.

Behaviour:
- Reset (rst_n=0 at a clk edge): slot index=0, slot counter=0, pending flag=0, shadow value/dots/digit_en/lzb=0, pending registers=0; segments=0, dp=0, digit_sel=0, frame_done=0, busy=0. Reset mid-slot or mid-pending discards everything; no partial frame.
- Slot counter counts 0..SCAN_DIV-1 and wraps. On wrap, index advances 0..DIGITS-1 and wraps to 0.
- Frame boundary: the cycle where counter=SCAN_DIV-1 and index=DIGITS-1.
- Outputs are registered: they reflect the (index, counter, shadow) state of the previous cycle. The first cycle after reset release is dark.
- Within a slot, counter < SCAN_DIV-BLANK_CYCLES is the ON phase; the rest is the BLANK phase (digit_sel=0, segments=0, dp=0).
- ON phase for digit k:
  - digit_sel = 1<<k.
  - segments = mapper(shadow nibble k).
  - dp = shadow dots[k].
  - If the digit is suppressed: digit_sel still asserted, segments=0, and dp still honoured.
- A digit is suppressed when shadow digit_en[k]=0, or when shadow lzb=1 and k>0 and every nibble k..DIGITS-1 is 0. Digit 0 is never suppressed by lzb.
- Update handshake:
  - An update pulse copies the inputs into pending registers and sets the pending flag (busy=1 from the next cycle).
  - Further updates before commit overwrite pending; last wins.
  - At a frame boundary with the pending flag set, pending is copied to shadow and the flag clears, so busy=0 the next cycle. Slot 0 of the next frame shows the new data.
  - Update on the frame boundary cycle itself: captured to pending, committed at the following boundary. The old pending, if any, is committed now, per the rule above.
- frame_done is registered: high for exactly the one cycle after each frame boundary cycle, every frame, whether or not a commit occurred.
- Inputs are not sampled except on update. Changing value without update has no effect.
- BLANK_CYCLES=0: no blank phase, and digit_sel moves directly between adjacent digits.

Test Plan:
All use DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset then idle 64 cycles -> digit_sel steps 0001,0010,0100,1000 (6 cycles on, 2 dark each); segments=0 throughout (shadow enable=0); frame_done pulses every 32 cycles.
- update with value=16'h12A5, dots=4'b0100, digit_en=4'hF, lzb=0 -> after next frame_done:
  - digit 0 segments=7'b1101101, digit 1 = 7'b1110111 (A), digit 2 = 7'b1011011 with dp=1, digit 3 = 7'b0000110.
  - busy high from the cycle after update until the commit.
- value=16'h0070, lzb=1, digit_en=4'hF -> digits 3 and 2 suppressed (segments=0), digit 1 shows 7'b0000111, digit 0 shows 7'b0111111.
- value=16'h0000, lzb=1 -> only digit 0 lit, showing 7'b0111111.
- Two updates in one frame (16'h1111, then 16'h2222), plus an update on the boundary cycle (16'h3333) -> next frame shows 2222, the frame after shows 3333; 1111 is never displayed.
- Assert rst_n=0 mid-slot while an update is pending -> outputs 0 on the next cycle; after release the display is dark and busy=0.
